// File: rtl/access_checker.sv
// Sequential code checker in front of a synchronous code ROM.
// Compares user digits against ROM contents and tracks failed attempts.
module access_checker #(
   parameter int DIGITS        = 4,
   parameter int ADDR_W        = 2,
   parameter int DATA_W        = 4,
   parameter int MAX_ATTEMPTS  = 3,
   parameter int UNLOCK_CYCLES = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DATA_W-1:0] i_digit_in,
   input  logic              i_digit_load,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [DATA_W-1:0] i_rom_data,
   output logic              o_busy,
   output logic              o_unlocked,
   output logic              o_denied,
   output logic              o_locked_out
);

   localparam int FW = (MAX_ATTEMPTS > 1) ? $clog2(MAX_ATTEMPTS) : 1;
   localparam int OW = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;

   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DIGITS - 1);
   localparam logic [FW-1:0]     FAIL_MAX  = FW'(MAX_ATTEMPTS - 1);
   localparam logic [OW-1:0]     OPEN_INIT = OW'(UNLOCK_CYCLES - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_CMP  = 3'd2;
   localparam logic [2:0] S_OPEN = 3'd3;
   localparam logic [2:0] S_FAIL = 3'd4;
   localparam logic [2:0] S_LOCK = 3'd5;

   logic [2:0]        r_state;
   logic [2:0]        w_state_nx;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] w_idx_nx;
   logic [DATA_W-1:0] r_dig;
   logic [DATA_W-1:0] w_dig_nx;
   logic              r_mis;
   logic              w_mis_nx;
   logic [FW-1:0]     r_fail_cnt;
   logic [FW-1:0]     w_fail_nx;
   logic [OW-1:0]     r_open_cnt;
   logic [OW-1:0]     w_open_nx;
   logic              r_load_q;
   logic              w_load_rise;
   logic              w_mis_cmp;
   logic              w_last;

   // Only a fresh strobe counts, so a held or early load is never replayed.
   assign w_load_rise = i_digit_load & ~r_load_q;
   assign w_mis_cmp   = r_mis | (r_dig != i_rom_data);
   assign w_last      = (r_idx == LAST_IDX);

   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_dig_nx   = r_dig;
      w_mis_nx   = r_mis;
      w_fail_nx  = r_fail_cnt;
      w_open_nx  = r_open_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (w_load_rise) begin
               w_dig_nx   = i_digit_in;
               w_state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            w_state_nx = S_CMP;
         end
         S_CMP: begin
            if (!w_last) begin
               w_mis_nx   = w_mis_cmp;
               w_idx_nx   = r_idx + 1'b1;
               w_state_nx = S_IDLE;
            end else begin
               w_idx_nx = '0;
               w_mis_nx = 1'b0;
               if (!w_mis_cmp) begin
                  w_fail_nx  = '0;
                  w_open_nx  = OPEN_INIT;
                  w_state_nx = S_OPEN;
               end else if (r_fail_cnt != FAIL_MAX) begin
                  w_fail_nx  = r_fail_cnt + 1'b1;
                  w_state_nx = S_FAIL;
               end else begin
                  w_state_nx = S_LOCK;
               end
            end
         end
         S_OPEN: begin
            if (r_open_cnt == '0) begin
               w_state_nx = S_IDLE;
            end else begin
               w_open_nx = r_open_cnt - 1'b1;
            end
         end
         S_FAIL: begin
            w_state_nx = S_IDLE;
         end
         S_LOCK: begin
            w_state_nx = S_LOCK;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_dig      <= '0;
         r_mis      <= 1'b0;
         r_fail_cnt <= '0;
         r_open_cnt <= '0;
         r_load_q   <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_idx      <= w_idx_nx;
         r_dig      <= w_dig_nx;
         r_mis      <= w_mis_nx;
         r_fail_cnt <= w_fail_nx;
         r_open_cnt <= w_open_nx;
         r_load_q   <= i_digit_load;
      end
   end

   assign o_rom_addr   = r_idx;
   assign o_busy       = (r_state != S_IDLE);
   assign o_unlocked   = (r_state == S_OPEN);
   assign o_denied     = (r_state == S_FAIL) | (r_state == S_LOCK);
   assign o_locked_out = (r_state == S_LOCK);

endmodule

// File: tb/tb_access_checker.sv
// Bench for access_checker: ROM model, timing-window reference model,
// directed scenarios and randomized code entry.
module tb_access_checker;

   localparam int DIGITS = 4;
   localparam int MAX_ATT = 3;
   localparam int UNL = 8;
   localparam int NEVER = 1 << 30;
   localparam logic [15:0] GOOD = 16'hA50F;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_digit_load = 1'b0;
   logic [3:0] i_digit_in = 4'h0;
   logic [3:0] i_rom_data;
   logic [1:0] o_rom_addr;
   logic       o_busy;
   logic       o_unlocked;
   logic       o_denied;
   logic       o_locked_out;

   logic [3:0] rom [4];
   assign rom[0] = 4'hA;
   assign rom[1] = 4'h5;
   assign rom[2] = 4'h0;
   assign rom[3] = 4'hF;

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) i_rom_data <= rom[o_rom_addr];

   access_checker dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_digit_in   (i_digit_in),
      .i_digit_load (i_digit_load),
      .o_rom_addr   (o_rom_addr),
      .i_rom_data   (i_rom_data),
      .o_busy       (o_busy),
      .o_unlocked   (o_unlocked),
      .o_denied     (o_denied),
      .o_locked_out (o_locked_out)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // Reference model: output windows derived from load times.
   int         m_ready;
   int         unl_s;
   int         unl_e;
   int         den_c;
   int         lock_c;
   int         addr_at;
   logic [1:0] m_addr;
   logic [1:0] addr_nx;
   int         m_fail;
   logic       m_prev;
   logic [3:0] att[$];
   logic       e_busy;
   logic       e_unl;
   logic       e_den;
   logic       e_lock;
   logic [1:0] e_addr;

   typedef struct {
      logic       ld;
      logic [3:0] d;
   } step_t;
   step_t seq[$];

   task automatic model_reset();
      m_ready = 0;
      unl_s = -100;
      unl_e = -100;
      den_c = -100;
      lock_c = NEVER;
      addr_at = NEVER;
      m_addr = 2'd0;
      addr_nx = 2'd0;
      m_fail = 0;
      m_prev = 1'b0;
      att.delete();
      e_busy = 1'b0;
      e_unl = 1'b0;
      e_den = 1'b0;
      e_lock = 1'b0;
      e_addr = 2'd0;
   endtask

   task automatic accept(input logic [3:0] d);
      bit ok;
      att.push_back(d);
      addr_at = cyc + 2;
      if (att.size() < DIGITS) begin
         m_ready = cyc + 3;
         addr_nx = 2'(att.size());
      end else begin
         ok = 1;
         for (int i = 0; i < DIGITS; i++)
            if (att[i] != GOOD[15-4*i -: 4]) ok = 0;
         addr_nx = 2'd0;
         att.delete();
         if (ok) begin
            m_fail = 0;
            unl_s = cyc + 2;
            unl_e = cyc + 1 + UNL;
            m_ready = cyc + 3 + UNL;
         end else if (m_fail < MAX_ATT - 1) begin
            m_fail++;
            den_c = cyc + 2;
            m_ready = cyc + 4;
         end else begin
            lock_c = cyc + 2;
            m_ready = NEVER;
         end
      end
   endtask

   task automatic tick(input logic ld, input logic [3:0] d);
      i_digit_load = ld;
      i_digit_in = d;
      @(posedge i_clk);
      cyc++;
      if (ld && !m_prev && cyc >= m_ready) accept(d);
      m_prev = ld;
      @(negedge i_clk);
      if (cyc >= addr_at) begin
         m_addr = addr_nx;
         addr_at = NEVER;
      end
      e_lock = (cyc >= lock_c);
      e_busy = e_lock || (cyc <= m_ready - 2);
      e_unl = (cyc >= unl_s) && (cyc <= unl_e);
      e_den = e_lock || (cyc == den_c);
      e_addr = m_addr;
   endtask

   task automatic apply_reset();
      #2;
      i_rst_n = 1'b0;
      i_digit_load = 1'b0;
      @(posedge i_clk);
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      model_reset();
   endtask

   task automatic push_code(input logic [15:0] c, input int gap);
      for (int i = 0; i < DIGITS; i++) begin
         seq.push_back('{1'b1, c[15-4*i -: 4]});
         for (int g = 0; g < gap; g++) seq.push_back('{1'b0, 4'h0});
      end
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) seq.push_back('{1'b0, 4'h0});
   endtask

   function automatic logic [5:0] obs();
      return {o_busy, o_unlocked, o_denied, o_locked_out, o_rom_addr};
   endfunction

   function automatic logic [5:0] expv();
      return {e_busy, e_unl, e_den, e_lock, e_addr};
   endfunction

   task automatic test_reset();
      i_rst_n = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      total++;
      if (obs() !== 6'b0) begin
         bad++;
         $display("FAIL reset_outputs got=%b exp=%b", obs(), 6'b0);
      end
      i_rst_n = 1'b1;
      model_reset();
      tick(1'b0, 4'h0);
      total++;
      if (obs() !== expv()) begin
         bad++;
         $display("FAIL reset_idle got=%b exp=%b", obs(), expv());
      end
   endtask

   task automatic test_correct_code();
      int n_unl = 0;
      int n_den = 0;
      logic [1:0] a_seen[$];
      seq.delete();
      push_code(GOOD, 3);
      push_idle(12);
      foreach (seq[i]) begin
         if (seq[i].ld) a_seen.push_back(o_rom_addr);
         tick(seq[i].ld, seq[i].d);
         total++;
         if (obs() !== expv()) begin
            bad++;
            $display("FAIL correct cyc=%0d got=%b exp=%b", cyc, obs(), expv());
         end
         n_unl += int'(o_unlocked);
         n_den += int'(o_denied);
      end
      total++;
      if (n_unl != UNL || n_den != 0) begin
         bad++;
         $display("FAIL correct_counts unl=%0d den=%0d exp=%0d/0", n_unl, n_den, UNL);
      end
      for (int i = 0; i < DIGITS; i++) begin
         total++;
         if (a_seen[i] !== 2'(i)) begin
            bad++;
            $display("FAIL correct_addr%0d got=%0d exp=%0d", i, a_seen[i], i);
         end
      end
   endtask

   task automatic test_wrong_code();
      int n_unl = 0;
      int n_den = 0;
      seq.delete();
      push_code(16'hA51F, 3);
      push_idle(4);
      foreach (seq[i]) begin
         tick(seq[i].ld, seq[i].d);
         total++;
         if (obs() !== expv()) begin
            bad++;
            $display("FAIL wrong cyc=%0d got=%b exp=%b", cyc, obs(), expv());
         end
         n_unl += int'(o_unlocked);
         n_den += int'(o_denied);
      end
      total++;
      if (n_unl != 0 || n_den != 1 || o_rom_addr !== 2'd0) begin
         bad++;
         $display("FAIL wrong_counts unl=%0d den=%0d addr=%0d exp=0/1/0", n_unl, n_den, o_rom_addr);
      end
   endtask

   task automatic test_early_mismatch();
      int n_ld = 0;
      int early = 0;
      int n_den = 0;
      seq.delete();
      push_code(16'h050F, 3);
      push_idle(4);
      foreach (seq[i]) begin
         n_ld += int'(seq[i].ld);
         tick(seq[i].ld, seq[i].d);
         total++;
         if (obs() !== expv()) begin
            bad++;
            $display("FAIL early cyc=%0d got=%b exp=%b", cyc, obs(), expv());
         end
         if (n_ld < DIGITS) early += int'(o_denied);
         n_den += int'(o_denied);
      end
      total++;
      if (early != 0 || n_den != 1) begin
         bad++;
         $display("FAIL early_counts early=%0d den=%0d exp=0/1", early, n_den);
      end
   endtask

   task automatic test_lockout();
      apply_reset();
      seq.delete();
      push_code(16'h1111, 3);
      push_idle(2);
      push_code(16'h2222, 3);
      push_idle(2);
      push_code(16'hA50E, 3);
      push_idle(3);
      push_code(GOOD, 3);
      push_idle(3);
      foreach (seq[i]) begin
         tick(seq[i].ld, seq[i].d);
         total++;
         if (obs() !== expv()) begin
            bad++;
            $display("FAIL lockout cyc=%0d got=%b exp=%b", cyc, obs(), expv());
         end
      end
      total++;
      if ({o_locked_out, o_denied, o_busy, o_unlocked} !== 4'b1110) begin
         bad++;
         $display("FAIL lockout_final got=%b exp=1110", {o_locked_out, o_denied, o_busy, o_unlocked});
      end
   endtask

   task automatic test_reset_mid_open();
      int n_unl = 0;
      apply_reset();
      seq.delete();
      push_code(GOOD, 3);
      push_idle(3);
      foreach (seq[i]) tick(seq[i].ld, seq[i].d);
      total++;
      if (o_unlocked !== 1'b1) begin
         bad++;
         $display("FAIL mid_open_pre got=%b exp=1", o_unlocked);
      end
      #2;
      i_rst_n = 1'b0;
      #1;
      total++;
      if (obs() !== 6'b0) begin
         bad++;
         $display("FAIL mid_open_async got=%b exp=%b", obs(), 6'b0);
      end
      @(posedge i_clk);
      @(negedge i_clk);
      total++;
      if (obs() !== 6'b0) begin
         bad++;
         $display("FAIL mid_open_held got=%b exp=%b", obs(), 6'b0);
      end
      i_rst_n = 1'b1;
      model_reset();
      seq.delete();
      push_code(GOOD, 3);
      push_idle(12);
      foreach (seq[i]) begin
         tick(seq[i].ld, seq[i].d);
         total++;
         if (obs() !== expv()) begin
            bad++;
            $display("FAIL mid_open_after cyc=%0d got=%b exp=%b", cyc, obs(), expv());
         end
         n_unl += int'(o_unlocked);
      end
      total++;
      if (n_unl != UNL) begin
         bad++;
         $display("FAIL mid_open_unl got=%0d exp=%0d", n_unl, UNL);
      end
   endtask

   task automatic test_counter_reset();
      int n_unl = 0;
      int n_den = 0;
      int n_lck = 0;
      apply_reset();
      seq.delete();
      push_code(16'h1234, 3);
      push_idle(2);
      push_code(16'h4321, 3);
      push_idle(2);
      push_code(GOOD, 3);
      push_idle(10);
      push_code(16'hFFFF, 3);
      push_idle(4);
      foreach (seq[i]) begin
         tick(seq[i].ld, seq[i].d);
         total++;
         if (obs() !== expv()) begin
            bad++;
            $display("FAIL cnt_reset cyc=%0d got=%b exp=%b", cyc, obs(), expv());
         end
         n_unl += int'(o_unlocked);
         n_den += int'(o_denied);
         n_lck += int'(o_locked_out);
      end
      total++;
      if (n_unl != UNL || n_den != 3 || n_lck != 0) begin
         bad++;
         $display("FAIL cnt_reset_counts unl=%0d den=%0d lck=%0d exp=%0d/3/0", n_unl, n_den, n_lck, UNL);
      end
   endtask

   task automatic test_hold_and_drop();
      int n_unl = 0;
      logic [1:0] a_hold;
      logic [1:0] a_drop;
      apply_reset();
      seq.delete();
      for (int i = 0; i < 5; i++) seq.push_back('{1'b1, 4'hA});
      push_idle(3);
      seq.push_back('{1'b1, 4'h5});
      seq.push_back('{1'b0, 4'h0});
      seq.push_back('{1'b1, 4'h7});
      push_idle(3);
      seq.push_back('{1'b1, 4'h0});
      push_idle(3);
      seq.push_back('{1'b1, 4'hF});
      push_idle(12);
      foreach (seq[i]) begin
         tick(seq[i].ld, seq[i].d);
         total++;
         if (obs() !== expv()) begin
            bad++;
            $display("FAIL hold_drop cyc=%0d got=%b exp=%b", cyc, obs(), expv());
         end
         if (i == 7) a_hold = o_rom_addr;
         if (i == 13) a_drop = o_rom_addr;
         n_unl += int'(o_unlocked);
      end
      total++;
      if (a_hold !== 2'd1 || a_drop !== 2'd2) begin
         bad++;
         $display("FAIL hold_drop_addr got=%0d/%0d exp=1/2", a_hold, a_drop);
      end
      total++;
      if (n_unl != UNL) begin
         bad++;
         $display("FAIL hold_drop_unl got=%0d exp=%0d", n_unl, UNL);
      end
   endtask

   task automatic test_random();
      logic [15:0] c;
      apply_reset();
      seq.delete();
      for (int a = 0; a < 30; a++) begin
         c = ($urandom_range(1, 0) == 1) ? GOOD : 16'($urandom);
         for (int i = 0; i < DIGITS; i++) begin
            for (int h = 0; h < int'($urandom_range(3, 1)); h++)
               seq.push_back('{1'b1, c[15-4*i -: 4]});
            push_idle(int'($urandom_range(4, 0)));
         end
      end
      push_idle(12);
      foreach (seq[i]) begin
         tick(seq[i].ld, seq[i].d);
         total++;
         if (obs() !== expv()) begin
            bad++;
            $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs(), expv());
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d limit reached", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      test_reset();
      test_correct_code();
      test_wrong_code();
      test_early_mismatch();
      test_lockout();
      test_reset_mid_open();
      test_counter_reset();
      test_hold_and_drop();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
